rbcp_axi_master: RTL and testbench

Bridge from the SiTCP RBCP byte-wide register port to a 32-bit AXI4-Lite master. It is the stage directly upstream of the 8-to-32 write adapter and the matching read path. Each RBCP single-byte access becomes one AXI-Lite transaction: a word-aligned address, a one-hot strobe and a byte-replicated data word. The block returns the RBCP ACK pulse when the AXI transaction completes, or when the timeout expires.

---
 rtl/rbcp_axi_pkg.sv | 28 ++
 rtl/rbcp_axi_master.sv | 227 ++++++++++++++++++++++
 tb/tb_rbcp_axi_master.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rbcp_axi_pkg.sv
// Shared definitions for the RBCP-to-AXI4-Lite bridge: state encoding,
// AXI constants and the byte-lane strobe helper.
package rbcp_axi_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_WB   = 3'd2;
    localparam logic [2:0] ST_RA   = 3'd3;
    localparam logic [2:0] ST_RR   = 3'd4;
    localparam logic [2:0] ST_ACK  = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        WR   = ST_WR,
        WB   = ST_WB,
        RA   = ST_RA,
        RR   = ST_RR,
        ACK  = ST_ACK
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0] PROT_DEFAULT  = 3'b000;

    function automatic logic [3:0] lane_strb(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/rbcp_axi_master.sv
// Turns each single-byte RBCP access into one 32-bit AXI4-Lite transaction
// and answers with an RBCP ack on completion or after a timeout.
module rbcp_axi_master
    import rbcp_axi_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rbcp_act,
    input  logic [31:0] rbcp_addr,
    input  logic        rbcp_we,
    input  logic [7:0]  rbcp_wd,
    input  logic        rbcp_re,
    output logic        rbcp_ack,
    output logic [7:0]  rbcp_rd,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        timeout_err,
    output logic        resp_err
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wd_q, wd_d;
    logic [3:0]  strb_q, strb_d;
    logic [15:0] cnt_q, cnt_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        act_lost_q, act_lost_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic        ack_q, ack_d, terr_q, terr_d, rerr_q, rerr_d;
    logic [7:0]  rd_q, rd_d;
    logic [15:0] cnt_next;
    logic        tmo_hit, expire, lost_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wd_q       <= '0;
            strb_q     <= '0;
            cnt_q      <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            act_lost_q <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            ack_q      <= 1'b0;
            terr_q     <= 1'b0;
            rerr_q     <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            strb_q     <= strb_d;
            cnt_q      <= cnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            act_lost_q <= act_lost_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            ack_q      <= ack_d;
            terr_q     <= terr_d;
            rerr_q     <= rerr_d;
            rd_q       <= rd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        strb_d     = strb_q;
        cnt_d      = cnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        act_lost_d = act_lost_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        rd_d       = rd_q;
        ack_d      = 1'b0;
        terr_d     = 1'b0;
        rerr_d     = 1'b0;
        expire     = 1'b0;
        cnt_next   = cnt_q + 16'd1;
        tmo_hit    = (cnt_next == TMO_LAST);
        lost_now   = act_lost_q | ~rbcp_act;

        if (state_q != IDLE && !rbcp_act) act_lost_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (rbcp_we) begin
                    state_d    = WR;
                    addr_d     = rbcp_addr;
                    wd_d       = rbcp_wd;
                    strb_d     = lane_strb(rbcp_addr[1:0]);
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    cnt_d      = '0;
                    act_lost_d = 1'b0;
                end else if (rbcp_re) begin
                    state_d    = RA;
                    addr_d     = rbcp_addr;
                    arvalid_d  = 1'b1;
                    cnt_d      = '0;
                    act_lost_d = 1'b0;
                end
            end
            WR: begin
                cnt_d = cnt_next;
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = WB;
                    bready_d = 1'b1;
                end else if (tmo_hit) begin
                    expire = 1'b1;
                end
            end
            WB: begin
                cnt_d = cnt_next;
                if (m_axi_bvalid) begin
                    state_d  = ACK;
                    bready_d = 1'b0;
                    ack_d    = ~lost_now;
                    rd_d     = 8'h00;
                    rerr_d   = (m_axi_bresp != AXI_RESP_OKAY);
                end else if (tmo_hit) begin
                    expire = 1'b1;
                end
            end
            RA: begin
                cnt_d = cnt_next;
                if (m_axi_arready) begin
                    state_d   = RR;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (tmo_hit) begin
                    expire = 1'b1;
                end
            end
            RR: begin
                cnt_d = cnt_next;
                if (m_axi_rvalid) begin
                    state_d  = ACK;
                    rready_d = 1'b0;
                    ack_d    = ~lost_now;
                    rd_d     = m_axi_rdata[{addr_q[1:0], 3'b000} +: 8];
                    rerr_d   = (m_axi_rresp != AXI_RESP_OKAY);
                end else if (tmo_hit) begin
                    expire = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The slave is considered dead: drop everything, even mid-handshake.
        if (expire) begin
            state_d   = ACK;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            terr_d    = 1'b1;
            rd_d      = 8'hFF;
            ack_d     = ~lost_now;
        end
    end

    assign rbcp_ack      = ack_q;
    assign rbcp_rd       = rd_q;
    assign m_axi_awaddr  = {addr_q[31:2], 2'b00};
    assign m_axi_araddr  = {addr_q[31:2], 2'b00};
    assign m_axi_awprot  = PROT_DEFAULT;
    assign m_axi_arprot  = PROT_DEFAULT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = {4{wd_q}};
    assign m_axi_wstrb   = strb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign timeout_err   = terr_q;
    assign resp_err      = rerr_q;

endmodule

// File: tb/tb_rbcp_axi_master.sv
// Directed bench for rbcp_axi_master: a vector table of single accesses
// against a scripted slave, plus hand-written reset and merge sequences.
module tb_rbcp_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        rbcp_act, rbcp_we, rbcp_re, rbcp_ack;
    logic [31:0] rbcp_addr;
    logic [7:0]  rbcp_wd, rbcp_rd;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        timeout_err, resp_err;

    always #5 clk = ~clk;

    rbcp_axi_master #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .rbcp_act(rbcp_act), .rbcp_addr(rbcp_addr),
        .rbcp_we(rbcp_we), .rbcp_wd(rbcp_wd), .rbcp_re(rbcp_re),
        .rbcp_ack(rbcp_ack), .rbcp_rd(rbcp_rd),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready), .timeout_err(timeout_err), .resp_err(resp_err)
    );

    typedef struct {
        logic        wr, rd;
        logic [31:0] addr;
        logic [7:0]  wd;
        int          aw_dly, w_dly, ar_dly;
        logic        b_en;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          inj_we, drop_act;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        int          e_lat;
        logic [7:0]  e_rd;
        int          e_acks, e_terr, e_rerr, e_awhs, e_bhs, e_rhs;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl [NVEC];

    int n_chk = 0, n_pass = 0;
    logic [31:0] obs_addr, obs_wdata, acc;
    logic [3:0]  obs_strb, acc_strb;
    logic [7:0]  obs_rd;
    logic [4:0]  obs_vld;
    logic        seen;
    int obs_lat, obs_acks, obs_terr, obs_rerr, obs_awhs, obs_bhs, obs_rhs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v);
        rbcp_addr = v.addr; rbcp_wd = v.wd; rbcp_we = v.wr; rbcp_re = v.rd;
        bvalid = v.b_en; bresp = v.bresp; rvalid = 1'b1; rdata = v.rdata; rresp = v.rresp;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        seen = 1'b0; obs_addr = 'x; obs_strb = 'x; obs_wdata = 'x; obs_rd = 'x;
        obs_lat = -1; obs_acks = 0; obs_terr = 0; obs_rerr = 0;
        obs_awhs = 0; obs_bhs = 0; obs_rhs = 0; obs_vld = '0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            rbcp_we = (c == v.inj_we);
            rbcp_re = 1'b0;
            if (c == v.drop_act) rbcp_act = 1'b0;
            awready = (c > v.aw_dly);
            wready  = (c > v.w_dly);
            arready = (c > v.ar_dly);
            if (!seen && (awvalid || arvalid)) begin
                seen = 1'b1;
                obs_addr  = awvalid ? awaddr : araddr;
                obs_strb  = wstrb;
                obs_wdata = wdata;
            end
            if (awvalid && awready) obs_awhs++;
            if (bvalid && bready) obs_bhs++;
            if (rvalid && rready) obs_rhs++;
            if (wvalid && wready)
                for (int i = 0; i < 4; i++)
                    if (wstrb[i]) begin
                        acc[8*i +: 8] = wdata[8*i +: 8];
                        acc_strb[i] = 1'b1;
                    end
            if (rbcp_ack) begin
                obs_acks++;
                if (obs_lat < 0) obs_lat = c;
                obs_rd = rbcp_rd;
                obs_vld |= {awvalid, wvalid, bready, arvalid, rready};
            end
            if (timeout_err) obs_terr++;
            if (resp_err) obs_rerr++;
        end
        rbcp_act = 1'b1;
    endtask

    function automatic vec_t mkwr(input logic [31:0] a, input logic [7:0] d);
        vec_t v;
        v = '{1'b1, 1'b0, a, d, 0, 0, 0, 1'b1, 2'b00, 32'h0, 2'b00, 0, 0,
              {a[31:2], 2'b00}, 4'b0001 << a[1:0], {4{d}}, 3, 8'h00, 1, 0, 0, 1, 1, 0};
        return v;
    endfunction

    initial begin
        //         wr rd addr          wd     awd wd ard ben bresp rdata         rresp inj drop e_addr        e_strb   e_wdata       lat rd     ack ter rer aw b r
        tbl[0] = '{1, 0, 32'h0000_1006, 8'hA5, 0, 0, 0, 1, 2'b00, 32'h0,        2'b00, 0, 0, 32'h0000_1004, 4'b0100, 32'hA5A5A5A5, 3, 8'h00, 1, 0, 0, 1, 1, 0};
        tbl[1] = '{0, 1, 32'h0000_2001, 8'h00, 0, 0, 5, 1, 2'b00, 32'hDEADBEEF, 2'b00, 0, 0, 32'h0000_2000, 4'b0000, 32'h0,        8, 8'hBE, 1, 0, 0, 0, 0, 1};
        tbl[2] = '{1, 0, 32'h0000_3003, 8'h5A, 0, 0, 0, 0, 2'b00, 32'h0,        2'b00, 0, 0, 32'h0000_3000, 4'b1000, 32'h5A5A5A5A, 16, 8'hFF, 1, 1, 0, 1, 0, 0};
        tbl[3] = '{1, 0, 32'h0000_4000, 8'hC3, 0, 0, 0, 1, 2'b10, 32'h0,        2'b00, 0, 0, 32'h0000_4000, 4'b0001, 32'hC3C3C3C3, 3, 8'h00, 1, 0, 1, 1, 1, 0};
        tbl[4] = '{1, 1, 32'h0000_5002, 8'h7E, 0, 0, 0, 1, 2'b00, 32'h0,        2'b00, 2, 0, 32'h0000_5000, 4'b0100, 32'h7E7E7E7E, 3, 8'h00, 1, 0, 0, 1, 1, 0};
        tbl[5] = '{0, 1, 32'h0000_6003, 8'h00, 0, 0, 0, 1, 2'b00, 32'h11223344, 2'b00, 0, 2, 32'h0000_6000, 4'b0000, 32'h0,        -1, 8'h00, 0, 0, 0, 0, 0, 1};
        tbl[6] = '{0, 1, 32'h0000_6003, 8'h00, 0, 0, 0, 1, 2'b00, 32'h11223344, 2'b00, 0, 0, 32'h0000_6000, 4'b0000, 32'h0,        3, 8'h11, 1, 0, 0, 0, 0, 1};
        tbl[7] = '{1, 0, 32'h0000_7001, 8'h3C, 2, 0, 0, 1, 2'b00, 32'h0,        2'b00, 0, 0, 32'h0000_7000, 4'b0010, 32'h3C3C3C3C, 5, 8'h00, 1, 0, 0, 1, 1, 0};
        tbl[8] = '{1, 0, 32'h0000_7002, 8'h96, 0, 3, 0, 1, 2'b00, 32'h0,        2'b00, 0, 0, 32'h0000_7000, 4'b0100, 32'h96969696, 6, 8'h00, 1, 0, 0, 1, 1, 0};
        tbl[9] = '{0, 1, 32'h0000_8000, 8'h00, 0, 0, 0, 1, 2'b00, 32'h000000C0, 2'b11, 0, 0, 32'h0000_8000, 4'b0000, 32'h0,        3, 8'hC0, 1, 0, 1, 0, 0, 1};

        rst = 1'b1; rbcp_act = 1'b1; rbcp_we = 1'b0; rbcp_re = 1'b0;
        rbcp_addr = '0; rbcp_wd = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        bresp = '0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        acc = '0; acc_strb = '0;
        repeat (3) tick();
        chk("reset_ctl", 32'({awvalid, wvalid, bready, arvalid, rready, rbcp_ack, timeout_err, resp_err}), 32'h0);
        chk("reset_rd", 32'(rbcp_rd), 32'h0);
        chk("reset_awaddr", awaddr, 32'h0);
        chk("reset_araddr", araddr, 32'h0);
        chk("reset_wdata", wdata, 32'h0);
        chk("reset_wstrb", 32'(wstrb), 32'h0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < NVEC; k++) begin
            run(tbl[k]);
            chk($sformatf("v%0d_addr", k), obs_addr, tbl[k].e_addr);
            if (tbl[k].wr) begin
                chk($sformatf("v%0d_wstrb", k), 32'(obs_strb), 32'(tbl[k].e_strb));
                chk($sformatf("v%0d_wdata", k), obs_wdata, tbl[k].e_wdata);
            end
            chk($sformatf("v%0d_ack_latency", k), 32'(obs_lat), 32'(tbl[k].e_lat));
            chk($sformatf("v%0d_ack_count", k), 32'(obs_acks), 32'(tbl[k].e_acks));
            if (tbl[k].e_acks > 0) begin
                chk($sformatf("v%0d_rbcp_rd", k), 32'(obs_rd), 32'(tbl[k].e_rd));
                chk($sformatf("v%0d_valids_at_ack", k), 32'(obs_vld), 32'h0);
            end
            chk($sformatf("v%0d_timeout_err", k), 32'(obs_terr), 32'(tbl[k].e_terr));
            chk($sformatf("v%0d_resp_err", k), 32'(obs_rerr), 32'(tbl[k].e_rerr));
            chk($sformatf("v%0d_aw_hs", k), 32'(obs_awhs), 32'(tbl[k].e_awhs));
            chk($sformatf("v%0d_b_hs", k), 32'(obs_bhs), 32'(tbl[k].e_bhs));
            chk($sformatf("v%0d_r_hs", k), 32'(obs_rhs), 32'(tbl[k].e_rhs));
        end

        // Four byte writes into one word, merged the way the downstream adapter would.
        acc = '0; acc_strb = '0;
        run(mkwr(32'h10, 8'h11));
        run(mkwr(32'h11, 8'h22));
        run(mkwr(32'h12, 8'h33));
        run(mkwr(32'h13, 8'h44));
        chk("merge_data", acc, 32'h44332211);
        chk("merge_strb", 32'(acc_strb), 32'hF);
        chk("merge_last_addr", obs_addr, 32'h10);

        // Reset while waiting for the write response.
        rbcp_addr = 32'h0000_9001; rbcp_wd = 8'h99; rbcp_we = 1'b1;
        bvalid = 1'b0; awready = 1'b1; wready = 1'b1;
        tick();
        rbcp_we = 1'b0;
        tick();
        tick();
        chk("rst_mid_in_wb", 32'(bready), 32'h1);
        rst = 1'b1;
        tick();
        chk("rst_mid_ctl", 32'({awvalid, wvalid, bready, arvalid, rready, rbcp_ack, timeout_err, resp_err}), 32'h0);
        chk("rst_mid_rd", 32'(rbcp_rd), 32'h0);
        chk("rst_mid_addr", awaddr, 32'h0);
        chk("rst_mid_wdata_strb", wdata | 32'(wstrb), 32'h0);
        rst = 1'b0; bvalid = 1'b1;
        obs_acks = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rbcp_ack || timeout_err) obs_acks++;
        end
        chk("rst_mid_no_ack", 32'(obs_acks), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
